// File: rtl/cluster_event_tx.sv
// Multi-channel event producer feeding a toggle-token slot buffer read from another clock domain.
// Round-robin arbitration across channels; when full, either backpressures or accepts and counts drops.
module cluster_event_tx #(
  parameter int N_CH         = 4,
  parameter int EVNT_WIDTH   = 8,
  parameter int BUFFER_WIDTH = 8,
  parameter int SYNC_STAGES  = 2,
  parameter int DROP_ON_FULL = 0
) (
  input  logic                                   clk_i,
  input  logic                                   rst_ni,
  input  logic [N_CH-1:0]                        evt_valid_i,
  input  logic [N_CH-1:0][EVNT_WIDTH-1:0]        evt_data_i,
  output logic [N_CH-1:0]                        evt_ack_o,
  output logic [BUFFER_WIDTH-1:0]                events_wt_o,
  input  logic [BUFFER_WIDTH-1:0]                events_rp_i,
  output logic [BUFFER_WIDTH-1:0][EVNT_WIDTH-1:0] events_da_o,
  output logic [$clog2(BUFFER_WIDTH):0]          level_o,
  output logic                                   full_o,
  output logic                                   empty_o,
  input  logic                                   clr_drop_i,
  output logic [7:0]                             drop_cnt_o
);

  localparam int IDX_W = $clog2(BUFFER_WIDTH);
  localparam int PTR_W = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int LVL_W = IDX_W + 1;

  logic [SYNC_STAGES-1:0][BUFFER_WIDTH-1:0]   rp_sync_q, rp_sync_d;
  logic [BUFFER_WIDTH-1:0]                    wt_q, wt_d;
  logic [BUFFER_WIDTH-1:0][EVNT_WIDTH-1:0]    data_q, data_d;
  logic [IDX_W-1:0]                           wr_idx_q, wr_idx_d;
  logic [PTR_W-1:0]                           rr_ptr_q, rr_ptr_d;
  logic [7:0]                                 drop_q, drop_d;

  logic [BUFFER_WIDTH-1:0] occ;
  logic [LVL_W-1:0]        level;
  logic                    full;
  logic                    grant_vld;
  logic [PTR_W-1:0]        grant_idx;
  logic [PTR_W-1:0]        cand;
  logic                    ack_any;
  logic                    wr_en;
  logic                    drop_en;

  // Slot occupancy is the disagreement between our write token and the synchronised read token.
  always_comb begin
    occ   = wt_q ^ rp_sync_q[SYNC_STAGES-1];
    level = '0;
    for (int unsigned k = 0; k < BUFFER_WIDTH; k++) begin
      level = level + LVL_W'(occ[k]);
    end
    full = occ[wr_idx_q];
  end

  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int unsigned k = 0; k < N_CH; k++) begin
      cand = PTR_W'((32'(rr_ptr_q) + k) % N_CH);
      if (!grant_vld && evt_valid_i[cand]) begin
        grant_vld = 1'b1;
        grant_idx = cand;
      end
    end
  end

  // Ack is masked during reset so nothing appears accepted while state is being cleared.
  always_comb begin
    evt_ack_o = '0;
    ack_any   = grant_vld && rst_ni && (!full || (DROP_ON_FULL != 0));
    if (ack_any) begin
      evt_ack_o[grant_idx] = 1'b1;
    end
    wr_en   = ack_any && !full;
    drop_en = ack_any && full;
  end

  always_comb begin
    rp_sync_d[0] = events_rp_i;
    for (int unsigned s = 1; s < SYNC_STAGES; s++) begin
      rp_sync_d[s] = rp_sync_q[s-1];
    end

    wt_d     = wt_q;
    data_d   = data_q;
    wr_idx_d = wr_idx_q;
    if (wr_en) begin
      data_d[wr_idx_q] = evt_data_i[grant_idx];
      wt_d[wr_idx_q]   = ~wt_q[wr_idx_q];
      wr_idx_d         = wr_idx_q + 1'b1;
    end

    rr_ptr_d = rr_ptr_q;
    if (ack_any) begin
      rr_ptr_d = PTR_W'((32'(grant_idx) + 1) % N_CH);
    end

    drop_d = drop_q;
    if (clr_drop_i) begin
      drop_d = '0;
    end else if (drop_en && (drop_q != 8'hFF)) begin
      drop_d = drop_q + 8'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rp_sync_q <= '0;
      wt_q      <= '0;
      data_q    <= '0;
      wr_idx_q  <= '0;
      rr_ptr_q  <= '0;
      drop_q    <= '0;
    end else begin
      rp_sync_q <= rp_sync_d;
      wt_q      <= wt_d;
      data_q    <= data_d;
      wr_idx_q  <= wr_idx_d;
      rr_ptr_q  <= rr_ptr_d;
      drop_q    <= drop_d;
    end
  end

  assign events_wt_o = wt_q;
  assign events_da_o = data_q;
  assign level_o     = level;
  assign full_o      = full;
  assign empty_o     = (level == '0);
  assign drop_cnt_o  = drop_q;

endmodule

// File: tb/tb_cluster_event_tx.sv
// Directed bench: one backpressure instance and one drop-on-full instance, checked against hand-derived values.
module tb_cluster_event_tx;

  logic clk;
  logic rst_n;

  logic [3:0]      v0, ack0;
  logic [3:0][7:0] d0;
  logic [7:0]      wt0, rp0;
  logic [7:0][7:0] da0;
  logic [3:0]      lvl0;
  logic            full0, empty0, clr0;
  logic [7:0]      drop0;

  logic [3:0]      v1, ack1;
  logic [3:0][7:0] d1;
  logic [7:0]      wt1, rp1;
  logic [7:0][7:0] da1;
  logic [3:0]      lvl1;
  logic            full1, empty1, clr1;
  logic [7:0]      drop1;

  int n_chk;
  int n_bad;
  int ack_cnt;

  cluster_event_tx #(
    .N_CH(4), .EVNT_WIDTH(8), .BUFFER_WIDTH(8), .SYNC_STAGES(2), .DROP_ON_FULL(0)
  ) dut0 (
    .clk_i(clk), .rst_ni(rst_n), .evt_valid_i(v0), .evt_data_i(d0), .evt_ack_o(ack0),
    .events_wt_o(wt0), .events_rp_i(rp0), .events_da_o(da0), .level_o(lvl0),
    .full_o(full0), .empty_o(empty0), .clr_drop_i(clr0), .drop_cnt_o(drop0)
  );

  cluster_event_tx #(
    .N_CH(4), .EVNT_WIDTH(8), .BUFFER_WIDTH(8), .SYNC_STAGES(2), .DROP_ON_FULL(1)
  ) dut1 (
    .clk_i(clk), .rst_ni(rst_n), .evt_valid_i(v1), .evt_data_i(d1), .evt_ack_o(ack1),
    .events_wt_o(wt1), .events_rp_i(rp1), .events_da_o(da1), .level_o(lvl1),
    .full_o(full1), .empty_o(empty1), .clr_drop_i(clr1), .drop_cnt_o(drop1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    #1;
  endtask

  initial begin
    n_chk = 0; n_bad = 0; ack_cnt = 0;
    rst_n = 1'b0;
    v0 = '0; d0 = '0; rp0 = '0; clr0 = 1'b0;
    v1 = '0; d1 = '0; rp1 = '0; clr1 = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    #1;

    check_eq("rst_level", 64'(lvl0), 64'd0);
    check_eq("rst_empty", 64'(empty0), 64'd1);
    check_eq("rst_full", 64'(full0), 64'd0);
    check_eq("rst_wt", 64'(wt0), 64'h00);
    check_eq("rst_drop", 64'(drop1), 64'd0);

    // single event on ch0
    v0[0] = 1'b1; d0[0] = 8'h5A;
    #1;
    check_eq("single_ack", 64'(ack0), 64'b0001);
    tick();
    v0 = '0;
    #1;
    check_eq("single_da0", 64'(da0[0]), 64'h5A);
    check_eq("single_wt", 64'(wt0), 64'h01);
    check_eq("single_lvl", 64'(lvl0), 64'd1);
    check_eq("single_empty", 64'(empty0), 64'd0);

    // all channels continuously valid: round robin
    do_reset();
    v0 = 4'hF;
    for (int i = 0; i < 4; i++) d0[i] = 8'(8'h10 + i);
    for (int c = 0; c < 5; c++) begin
      #1;
      check_eq($sformatf("rr_ack%0d", c), 64'(ack0), 64'(4'b0001 << (c % 4)));
      tick();
    end
    v0 = '0;
    #1;
    check_eq("rr_wt", 64'(wt0), 64'h1F);
    check_eq("rr_lvl", 64'(lvl0), 64'd5);
    check_eq("rr_da1", 64'(da0[1]), 64'h11);
    check_eq("rr_da4", 64'(da0[4]), 64'h10);

    // asynchronous reset with 5 events buffered
    rst_n = 1'b0;
    #1;
    check_eq("arst_wt", 64'(wt0), 64'h00);
    check_eq("arst_lvl", 64'(lvl0), 64'd0);
    check_eq("arst_empty", 64'(empty0), 64'd1);
    check_eq("arst_full", 64'(full0), 64'd0);
    check_eq("arst_da0", 64'(da0[0]), 64'h00);
    tick();
    rst_n = 1'b1;
    v0[2] = 1'b1; d0[2] = 8'h77;
    #1;
    check_eq("post_rst_ack", 64'(ack0), 64'b0100);
    tick();
    v0 = '0;
    #1;
    check_eq("post_rst_da0", 64'(da0[0]), 64'h77);
    check_eq("post_rst_wt", 64'(wt0), 64'h01);

    // backpressure: fill 8 slots, then release slot 0 through the synchroniser
    do_reset();
    v0[0] = 1'b1;
    for (int i = 0; i < 8; i++) begin
      d0[0] = 8'(8'hA0 + i);
      #1;
      check_eq($sformatf("fill_ack%0d", i), 64'(ack0), 64'b0001);
      tick();
    end
    d0[0] = 8'hEE;
    #1;
    check_eq("bp_lvl", 64'(lvl0), 64'd8);
    check_eq("bp_full", 64'(full0), 64'd1);
    check_eq("bp_noack", 64'(ack0), 64'b0000);
    rp0[0] = 1'b1;
    #1;
    check_eq("bp_ack_e0", 64'(ack0), 64'b0000);
    tick();
    check_eq("bp_ack_e1", 64'(ack0), 64'b0000);
    tick();
    check_eq("bp_ack_e2", 64'(ack0), 64'b0001);
    check_eq("bp_lvl7", 64'(lvl0), 64'd7);
    tick();
    v0 = '0;
    #1;
    check_eq("bp_wt", 64'(wt0), 64'hFE);
    check_eq("bp_da0", 64'(da0[0]), 64'hEE);
    check_eq("bp_da1", 64'(da0[1]), 64'hA1);
    check_eq("bp_refull", 64'(full0), 64'd1);
    check_eq("bp_lvl8", 64'(lvl0), 64'd8);

    // drop-on-full instance
    do_reset();
    v1[3] = 1'b1;
    for (int i = 0; i < 8; i++) begin
      d1[3] = 8'(8'hB0 + i);
      #1;
      check_eq($sformatf("dfill_ack%0d", i), 64'(ack1), 64'b1000);
      tick();
    end
    d1[3] = 8'hCC;
    #1;
    check_eq("d_full", 64'(full1), 64'd1);
    check_eq("d_wt_full", 64'(wt1), 64'hFF);
    ack_cnt = 0;
    for (int i = 0; i < 300; i++) begin
      #1;
      if (ack1 == 4'b1000) ack_cnt++;
      tick();
    end
    check_eq("d_acks", 64'(ack_cnt), 64'd300);
    check_eq("d_sat", 64'(drop1), 64'd255);
    check_eq("d_wt", 64'(wt1), 64'hFF);
    check_eq("d_da0", 64'(da1[0]), 64'hB0);
    check_eq("d_da7", 64'(da1[7]), 64'hB7);
    clr1 = 1'b1;
    tick();
    check_eq("d_clr_prio", 64'(drop1), 64'd0);
    clr1 = 1'b0;
    tick();
    check_eq("d_after_clr", 64'(drop1), 64'd1);
    v1 = '0;
    tick();
    check_eq("d_idle_hold", 64'(drop1), 64'd1);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
